// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : aes_round_ctrl
// Brief   : Iterative AES-128 encryption sequencer, one round per clock.
// Revision: 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
    parameter int NR      = 10,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:127]       in_data,
    input  logic [0:127]       in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:127]       out_data,
    output logic [0:127]       dp_state,
    output logic [0:127]       dp_key,
    output logic               dp_last,
    input  logic [0:127]       dp_result,
    output logic [0:127]       ks_prev,
    output logic [7:0]         ks_rcon,
    input  logic [0:127]       ks_key,
    output logic [ROUND_W-1:0] round,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } fsm_t;

    localparam logic [ROUND_W-1:0] c_last_round = ROUND_W'(NR);
    localparam logic [ROUND_W-1:0] c_first_round = ROUND_W'(1);
    localparam logic [7:0]         c_rcon_init  = 8'h01;

    fsm_t               fsm_q,   fsm_d;
    logic [0:127]       state_q, state_d;
    logic [0:127]       key_q,   key_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [7:0]         rcon_q,  rcon_d;

    logic w_in_round;
    logic w_is_last;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= c_rcon_init;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    assign w_in_round = (fsm_q == ST_ROUND);
    assign w_is_last  = w_in_round && (round_q == c_last_round);

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = in_data ^ in_key;
                    key_d   = in_key;
                    round_d = c_first_round;
                    rcon_d  = c_rcon_init;
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_d = dp_result;
                key_d   = ks_key;
                // xtime: multiply by x in GF(2^8) to advance Rcon
                rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
                if (w_is_last) begin
                    round_d = '0;
                    fsm_d   = ST_DONE;
                end else begin
                    round_d = round_q + c_first_round;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (fsm_q == ST_IDLE);
    assign out_valid = (fsm_q == ST_DONE);
    assign busy      = w_in_round;
    assign out_data  = state_q;
    assign dp_state  = state_q;
    assign dp_key    = ks_key;
    assign dp_last   = w_is_last;
    assign ks_prev   = key_q;
    assign ks_rcon   = w_in_round ? rcon_q : 8'h00;
    assign round     = round_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_round_ctrl
// Brief   : Bench for aes_round_ctrl with a behavioural AES round/key datapath.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int RW = 4;

    localparam logic [0:127] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] PT2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [7:0] RC_EXP [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic          in_ready, out_valid, dp_last, busy;
    logic [0:127]  in_data, in_key, out_data, dp_state, dp_key, dp_result;
    logic [0:127]  ks_prev, ks_key;
    logic [7:0]    ks_rcon;
    logic [RW-1:0] round;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(NR), .ROUND_W(RW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .dp_state(dp_state), .dp_key(dp_key), .dp_last(dp_last), .dp_result(dp_result),
        .ks_prev(ks_prev), .ks_rcon(ks_rcon), .ks_key(ks_key),
        .round(round), .busy(busy)
    );

    // ---------------- GF(2^8) and AES primitives ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] l = x << n;
        logic [7:0] r = x >> (8 - n);
        return l | r;
    endfunction

    // Multiplicative inverse as a^254, then the FIPS-197 affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        logic [7:0] p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [0:127] aes_round(input logic [0:127] s, input logic [0:127] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [0:127] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[8*i +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r + 4*c] = b[r + 4*((c + r) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = t[i] ^ k[8*i +: 8];
        return o;
    endfunction

    function automatic logic [0:127] key_expand(input logic [0:127] prev, input logic [7:0] rc);
        logic [7:0]   t [4];
        logic [0:127] n;
        for (int j = 0; j < 4; j++) t[j] = sbox(prev[8*(12 + ((j + 1) % 4)) +: 8]);
        t[0] = t[0] ^ rc;
        for (int i = 0; i < 16; i++)
            n[8*i +: 8] = prev[8*i +: 8] ^ ((i < 4) ? t[i] : n[8*(i-4) +: 8]);
        return n;
    endfunction

    function automatic logic [7:0] rcon_of(input int r);
        logic [7:0] rc = 8'h01;
        for (int i = 1; i < r; i++) rc = xt(rc);
        return rc;
    endfunction

    function automatic logic [0:127] aes_encrypt(input logic [0:127] pt, input logic [0:127] key);
        logic [0:127] k = key;
        logic [0:127] s = pt ^ key;
        for (int r = 1; r <= NR; r++) begin
            k = key_expand(k, rcon_of(r));
            s = aes_round(s, k, r == NR);
        end
        return s;
    endfunction

    // External round datapath and key-expansion step
    always_comb begin
        ks_key    = key_expand(ks_prev, ks_rcon);
        dp_result = aes_round(dp_state, dp_key, dp_last);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- Transaction-level reference and per-cycle compare ----------------
    int           m_mode = 0;  // 0 idle, 1 computing, 2 result held
    int           m_cnt  = 0;
    logic         m_ok   = 1'b0;
    logic [0:127] m_exp  = '0;

    always @(negedge clk) begin
        if (m_ok) begin
            check("mon_in_ready",  in_ready,  m_mode == 0);
            check("mon_busy",      busy,      m_mode == 1);
            check("mon_out_valid", out_valid, m_mode == 2);
            check("mon_round",     round,     (m_mode == 1) ? m_cnt : 0);
            check("mon_dp_last",   dp_last,   (m_mode == 1) && (m_cnt == NR));
            if (m_mode == 1) check("mon_rcon", ks_rcon, rcon_of(m_cnt));
            if (m_mode == 2) check("mon_out_data", out_data, m_exp);
        end
        if (reset || flush) begin
            m_mode = 0;
            m_cnt  = 0;
            m_ok   = 1'b1;
        end else if (m_ok) begin
            if (m_mode == 0 && in_valid) begin
                m_mode = 1;
                m_cnt  = 1;
                m_exp  = aes_encrypt(in_data, in_key);
            end else if (m_mode == 1) begin
                if (m_cnt == NR) begin
                    m_mode = 2;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end else if (m_mode == 2 && out_ready) begin
                m_mode = 0;
            end
        end
    end

    // ---------------- Directed stimulus ----------------
    logic [7:0] rc_q[$];
    logic       last_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [0:127] pt, input logic [0:127] key, input logic keep);
        int n = 0;
        in_data  = pt;
        in_key   = key;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("accept_wait", in_ready, 1'b1);
        step();
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        rc_q.delete();
        last_q.delete();
        while (!out_valid && lat < 40) begin
            if (busy) begin
                rc_q.push_back(ks_rcon);
                last_q.push_back(dp_last);
            end
            step();
            lat++;
        end
        check("out_valid_wait", out_valid, 1'b1);
    endtask

    initial begin
        int           lat;
        int           n;
        logic [0:127] hold;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_key = '0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_round",     round,     0);
        check("rst_out_data",  out_data,  0);
        check("rst_dp_last",   dp_last,   1'b0);

        // Pin the reference against the FIPS-197 vectors
        check("model_appB",  aes_encrypt(PT1, K1), CT1);
        check("model_appC1", aes_encrypt(PT2, K2), CT2);
        check("model_rcon9", rcon_of(9), 8'h1B);

        // Vector 1: latency, Rcon sequence, dp_last, then backpressure
        send(PT1, K1, 1'b0);
        wait_valid(lat);
        check("v1_latency",  lat, NR);
        check("v1_out_data", out_data, CT1);
        check("v1_round_done", round, 0);
        check("v1_rcon_count", rc_q.size(), NR);
        for (int i = 0; i < 10; i++) begin
            if (i < rc_q.size()) begin
                check("v1_rcon_seq", rc_q[i], RC_EXP[i]);
                check("v1_dp_last",  last_q[i], i == NR - 1);
            end
        end
        hold = out_data;
        repeat (5) begin
            step();
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_data",  out_data,  hold);
            check("bp_in_ready",  in_ready,  1'b0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_in_ready",  in_ready,  1'b1);
        check("bp_release_out_valid", out_valid, 1'b0);

        // Vector 2 offered throughout vector 1's rounds is ignored until idle
        out_ready = 1'b1;
        send(PT1, K1, 1'b1);
        in_data = PT2;
        in_key  = K2;
        wait_valid(lat);
        check("ovl_first_data", out_data, CT1);
        step();
        check("ovl_gap_in_ready", in_ready, 1'b1);
        check("ovl_gap_busy",     busy,     1'b0);
        step();
        in_valid = 1'b0;
        check("ovl_second_busy",  busy,  1'b1);
        check("ovl_second_round", round, 1);
        wait_valid(lat);
        check("ovl_second_data", out_data, CT2);
        step();

        // Abort at round 5 via reset, then via flush; vector 2 runs cleanly afterwards
        for (int k = 0; k < 2; k++) begin
            send(PT1, K1, 1'b0);
            n = 0;
            while (round != 5 && n < 20) begin
                step();
                n++;
            end
            check("abort_at_round5", round, 5);
            if (k == 0) reset = 1'b1; else flush = 1'b1;
            step();
            reset = 1'b0;
            flush = 1'b0;
            check("abort_in_ready",  in_ready,  1'b1);
            check("abort_round",     round,     0);
            check("abort_out_valid", out_valid, 1'b0);
            check("abort_busy",      busy,      1'b0);
            send(PT2, K2, 1'b0);
            wait_valid(lat);
            check("abort_after_latency", lat, NR);
            check("abort_after_data", out_data, CT2);
            step();
        end

        out_ready = 1'b0;
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
